// File: rtl/operand_entry_ctrl.sv
// Operand-entry controller: synchronizes the board switches, debounces the
// clear / step-A / step-B channels with auto-repeat, and holds the two
// operands, which wrap modulo NUM_MAX+1.
module operand_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_RATE     = 4,
    parameter int unsigned NUM_MAX         = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  SW,
    output logic [31:0] numA,
    output logic [31:0] numB,
    output logic        upd
);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ARM,
        CH_HOLD,
        CH_REPEAT
    } ch_state_e;

    // Channel 0 = clear, 1 = step A, 2 = step B.
    localparam int unsigned NCH = 3;

    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;

    ch_state_e   state_q [NCH];
    ch_state_e   state_d [NCH];
    logic [31:0] cnt_q   [NCH];
    logic [31:0] cnt_d   [NCH];
    logic [NCH-1:0] fire;

    logic [31:0] numA_q, numA_d;
    logic [31:0] numB_q, numB_d;
    logic        upd_q,  upd_d;

    // Wrap-around step on a 33-bit datapath so v+10 cannot overflow.
    function automatic logic [31:0] step_val(input logic [31:0] v,
                                             input logic        down,
                                             input logic        big);
        logic [32:0] s;
        logic [32:0] lim;
        logic [32:0] v33;
        logic [32:0] t;
        s   = big ? 33'd10 : 33'd1;
        lim = 33'(NUM_MAX) + 33'd1;
        v33 = {1'b0, v};
        if (!down) begin
            t = v33 + s;
            if (t > 33'(NUM_MAX)) begin
                t = t - lim;
            end
        end else begin
            if (v33 >= s) begin
                t = v33 - s;
            end else begin
                t = v33 + lim - s;
            end
        end
        return 32'(t);
    endfunction

    // Two-flop synchronizer for all switch inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SW;
            sync2_q <= sync1_q;
        end
    end

    // Channel state and counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                state_q[i] <= CH_IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Channel next-state: debounce, first fire, delayed auto-repeat.
    // The counter restarts at 1 on each transition so that "cnt == N" fires
    // exactly N cycles after the previous event.
    always_comb begin
        fire = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!sync2_q[i]) begin
                state_d[i] = CH_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    CH_IDLE: begin
                        state_d[i] = CH_ARM;
                        cnt_d[i]   = 32'd1;
                    end
                    CH_ARM: begin
                        if (cnt_q[i] == DEBOUNCE_CYCLES) begin
                            fire[i]    = 1'b1;
                            state_d[i] = CH_HOLD;
                            cnt_d[i]   = 32'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 32'd1;
                        end
                    end
                    CH_HOLD: begin
                        // Clear never repeats: it parks here until release.
                        if (i != 32'd0) begin
                            if (cnt_q[i] == REPEAT_DELAY) begin
                                fire[i]    = 1'b1;
                                state_d[i] = CH_REPEAT;
                                cnt_d[i]   = 32'd1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 32'd1;
                            end
                        end
                    end
                    CH_REPEAT: begin
                        if (cnt_q[i] == REPEAT_RATE) begin
                            fire[i] = 1'b1;
                            cnt_d[i] = 32'd1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        state_d[i] = CH_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Operand update: clear wins over any same-cycle step.
    always_comb begin
        numA_d = numA_q;
        numB_d = numB_q;
        upd_d  = 1'b0;
        if (fire[0]) begin
            numA_d = '0;
            numB_d = '0;
            upd_d  = 1'b1;
        end else begin
            if (fire[1]) begin
                numA_d = step_val(numA_q, sync2_q[3], sync2_q[4]);
                upd_d  = 1'b1;
            end
            if (fire[2]) begin
                numB_d = step_val(numB_q, sync2_q[3], sync2_q[4]);
                upd_d  = 1'b1;
            end
        end
    end

    // Operand and update-pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            numA_q <= '0;
            numB_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            numA_q <= numA_d;
            numB_q <= numB_d;
            upd_q  <= upd_d;
        end
    end

    assign numA = numA_q;
    assign numB = numB_q;
    assign upd  = upd_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl: run-length based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_operand_entry_ctrl;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 4;
    localparam int NM = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  SW = '0;
    logic [31:0] numA;
    logic [31:0] numB;
    logic        upd;

    always #5 clk = ~clk;

    operand_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .NUM_MAX(NM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .SW(SW),
        .numA(numA),
        .numB(numB),
        .upd(upd)
    );

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a channel fires when its synchronized run length
    // (cycles high, including the current one) hits D+1, or for step channels
    // D+1+RD+m*RR.
    function automatic bit fires(input int c, input int hh);
        if (hh == D + 1) return 1'b1;
        if (c == 0) return 1'b0;
        if (hh >= D + 1 + RD && ((hh - (D + 1 + RD)) % RR) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint stepm(input longint v, input bit dn, input bit big);
        longint s;
        s = big ? 10 : 1;
        return dn ? (v + NM + 1 - s) % (NM + 1) : (v + s) % (NM + 1);
    endfunction

    longint   mA = 0;
    longint   mB = 0;
    bit       mUpd = 1'b0;
    bit [4:0] s1 = '0;
    bit [4:0] s2 = '0;
    int       h [3] = '{0, 0, 0};
    bit       f [3];
    int       cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mA = 0; mB = 0; mUpd = 1'b0; s1 = '0; s2 = '0;
            for (int c = 0; c < 3; c++) h[c] = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                h[c] = s2[c] ? h[c] + 1 : 0;
                f[c] = fires(c, h[c]);
            end
            mUpd = f[0] | f[1] | f[2];
            if (f[0]) begin
                mA = 0; mB = 0;
            end else begin
                if (f[1]) mA = stepm(mA, s2[3], s2[4]);
                if (f[2]) mB = stepm(mB, s2[3], s2[4]);
            end
            s2 = s1;
            s1 = SW;
        end
    end

    bit chk_en = 1'b0;
    int upd_cnt = 0;
    int first_upd = -1;
    int last_upd = -1;

    // Per-cycle compare against the model, plus upd bookkeeping.
    always @(negedge clk) begin
        if (chk_en) begin
            check("numA", numA, mA);
            check("numB", numB, mB);
            check("upd", upd, mUpd);
            if (upd) begin
                upd_cnt++;
                if (first_upd < 0) first_upd = cyc;
                last_upd = cyc;
            end
        end
    end

    task automatic clr_stats();
        upd_cnt = 0; first_upd = -1; last_upd = -1;
    endtask

    // Hold the pattern for n sampling edges, release, then let it settle.
    task automatic press(input logic [4:0] pat, input int n, output int e0);
        SW = pat;
        e0 = cyc + 1;
        repeat (n) @(negedge clk);
        SW[2:0] = '0;
        repeat (6) @(negedge clk);
    endtask

    int e0;
    int r0;

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        repeat (5) begin
            check("rst_numA", numA, 0);
            check("rst_numB", numB, 0);
            check("rst_upd", upd, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Glitch shorter than debounce.
        clr_stats();
        press(5'b00010, 3, e0);
        check("glitch_numA", numA, 0);
        check("glitch_upd", upd_cnt, 0);

        // Held 16 cycles: steps at edges 6 and 14.
        clr_stats();
        press(5'b00010, 16, e0);
        check("hold_numA", numA, 2);
        check("hold_updcnt", upd_cnt, 2);
        check("hold_first_edge", first_upd - e0, 6);
        check("hold_second_edge", last_upd - e0, 14);

        // B wraps down 0 -> 9999.
        clr_stats();
        press(5'b01100, 8, e0);
        check("wrapdn_numB", numB, 9999);
        check("wrapdn_updcnt", upd_cnt, 1);

        // B up by 1 four times: 9999 -> 3.
        press(5'b00100, 22, e0);
        check("b_to_3", numB, 3);

        // B down by 10 from 3 -> 9993.
        press(5'b11100, 8, e0);
        check("wrapdn10_numB", numB, 9993);

        // A down by 1 seven times: 2 -> 9995.
        press(5'b01010, 34, e0);
        check("a_to_9995", numA, 9995);

        // A up by 10 from 9995 wraps to 5.
        press(5'b10010, 8, e0);
        check("wrapup10_numA", numA, 5);

        // A and B together: one upd, both step.
        clr_stats();
        press(5'b00110, 8, e0);
        check("both_numA", numA, 6);
        check("both_numB", numB, 9994);
        check("both_updcnt", upd_cnt, 1);

        // Clear and A together from numA=7.
        press(5'b00010, 8, e0);
        check("a_to_7", numA, 7);
        clr_stats();
        press(5'b00011, 8, e0);
        check("clr_numA", numA, 0);
        check("clr_numB", numB, 0);
        check("clr_updcnt", upd_cnt, 1);

        // Reset mid-press: full debounce repeats afterwards.
        SW = 5'b00010;
        e0 = cyc + 1;
        repeat (10) @(negedge clk);
        check("pre_rst_numA", numA, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_numA", numA, 0);
        check("midrst_upd", upd, 0);
        rst_n = 1'b1;
        r0 = cyc + 1;
        clr_stats();
        repeat (8) @(negedge clk);
        check("post_rst_edge", first_upd - r0, 6);
        check("post_rst_numA", numA, 1);
        SW = '0;
        repeat (6) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Sequential operand-entry controller for the calculator. It converts the raw board switch levels SW[4:0] into debounced, edge-triggered and auto-repeating step commands, and it holds the two 32-bit operands numA and numB that feed the ALU/display path. It replaces combinational switch-to-number mapping with registered operands that wrap modulo NUM_MAX+1.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles required before a press is accepted (≥1; set to 500000 for the board build).
- REPEAT_DELAY, 8: cycles from the first step of a held press to the first auto-repeat step (≥1).
- REPEAT_RATE, 4: cycles between subsequent auto-repeat steps (≥1).
- NUM_MAX, 9999: largest operand value (9 ≤ NUM_MAX ≤ 2^32−11).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- SW  in  5  raw asynchronous switch levels. SW[0]=clear, SW[1]=step A, SW[2]=step B, SW[3]=direction (0 up, 1 down), SW[4]=step size (0 → 1, 1 → 10).
- numA  out  32  operand A, registered.
- numB  out  32  operand B, registered.
- upd  out  1  one-cycle pulse, coincident with the first cycle in which a new numA/numB value is visible.

## Operation
- All five SW bits pass through a 2-flop synchronizer. Only the synchronized values are used internally.
- SW[0], SW[1] and SW[2] each have an independent channel FSM with a shared-width counter:
  - IDLE: counter = 0. A synchronized-high value → ARM.
  - ARM: counts consecutive highs. On reaching DEBOUNCE_CYCLES the channel fires one step → HOLD.
  - HOLD: counts to REPEAT_DELAY, then fires → REPEAT. The clear channel (SW[0]) never leaves HOLD and never repeats.
  - REPEAT: fires every REPEAT_RATE cycles.
  - A synchronized-low value in any state → IDLE, counter cleared, with no fire that cycle.
- Step arithmetic:
  - Step size s is 1 or 10, taken from synchronized SW[4] in the fire cycle. Direction is taken from synchronized SW[3] in the fire cycle.
  - Up: v' = v+s if v+s ≤ NUM_MAX, else v+s−(NUM_MAX+1).
  - Down: v' = v−s if v ≥ s, else v+(NUM_MAX+1)−s.
  - Computation is done at 33 bits. The result is always in 0..NUM_MAX.
- Simultaneous events:
  - A and B firing in the same cycle: both update on the same edge, with a single upd pulse.
  - A clear fire takes priority: numA = numB = 0 that edge, and any same-cycle A/B step is discarded.
- upd is asserted for every fire that is accepted, including a clear, or a step that wraps to the same value.

## Timing
- Reset (rst_n low at a rising edge) sets numA = 0, numB = 0, upd = 0, synchronizer flops = 0, all FSMs = IDLE, and counters = 0. Reset overrides every other event in that cycle.
- First step latency: if SW[n] is first sampled high at edge 0 and stays high, the channel fires so that the new value and upd appear after edge DEBOUNCE_CYCLES+2. With the default parameters this is edge 6.
- Auto-repeat steps follow at +REPEAT_DELAY edges after the first step (edge 14), then every +REPEAT_RATE edges (edges 18, 22, …).
- Release latency is 2 edges (the synchronizer). No fire can occur once a synchronized low has been seen.
- Reset applied mid-press: after rst_n returns high with SW still held, the full debounce is repeated. The first step appears DEBOUNCE_CYCLES+2 edges after the first edge with rst_n high.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no step and no upd.
- numA, numB and upd change only on clock edges and have no combinational path from SW.

## Test plan
All scenarios use the default parameters.
- Reset with SW=0 for 5 cycles → numA=0, numB=0, upd=0 throughout.
- SW[1] high for 3 cycles then low (glitch) → numA stays 0, no upd. SW[1] high for 16 cycles then low → exactly two steps, at edges 6 and 14 → numA=2, and upd pulses twice.
- numB=0, SW[3]=1, SW[4]=0, SW[2] high for 8 cycles → numB=9999 (wrap down), one upd. Repeating with SW[4]=1 from numB=3 → numB=9993.
- numA=9995, SW[3]=0, SW[4]=1, SW[1] high for 8 cycles → numA=5 (wrap up).
- SW[1] and SW[2] rise in the same cycle → both operands step on the same edge, with a single upd. SW[0] and SW[1] rising together from numA=7 → numA=0, numB=0.
- SW[1] held, with rst_n pulled low at cycle 10 for 2 cycles → numA=0 during reset. The next step appears exactly 6 edges after rst_n returns high.
